// File: rtl/reaction_pkg.sv
// reaction_pkg: shared state encoding, default widths and LFSR constants for the reaction arena
package reaction_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, REACT, DONE} state_t;
  localparam int TIME_W_DEF = 14;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
endpackage

// File: rtl/reaction_lfsr.sv
// reaction_lfsr: free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11), low OUT_W bits exposed
module reaction_lfsr import reaction_pkg::*; #(
  parameter logic [15:0] SEED = LFSR_SEED_DEF,
  parameter int OUT_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  output logic [OUT_W-1:0] value
);
  logic [15:0] state;
  always_ff @(posedge clk)
    state <= reset ? SEED : (state >> 1) ^ (state[0] ? LFSR_TAPS : 16'h0);
  assign value = state[OUT_W-1:0];
endmodule

// File: rtl/reaction_arena.sv
// reaction_arena: multi-player reaction timer with false-start disqualification and session best
module reaction_arena import reaction_pkg::*; #(
  parameter int N_PLAYERS = 4,
  parameter int TIME_W = TIME_W_DEF,
  parameter int TICK_DIV = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_W = 11,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_btn,
  input  logic [N_PLAYERS-1:0]         react_btn,
  output logic                         led,
  output logic                         busy,
  output logic                         result_valid,
  output logic                         no_winner,
  output logic [$clog2(N_PLAYERS)-1:0] winner_id,
  output logic [TIME_W-1:0]            winner_time,
  output logic [N_PLAYERS-1:0]         false_start,
  output logic [TIME_W-1:0]            best_time,
  output logic [$clog2(N_PLAYERS)-1:0] best_id
);
  localparam int ID_W = $clog2(N_PLAYERS);
  localparam int TICK_W = $clog2(TICK_DIV + 1);
  localparam logic [TIME_W-1:0] T_MAX = '1;
  state_t state, state_n;
  logic [TICK_W-1:0] tick_cnt;
  logic [TIME_W:0] delay, delay_n;
  logic [TIME_W-1:0] elapsed, elapsed_n, winner_time_n;
  logic [N_PLAYERS-1:0] react_q, react_edge, valid, fs_n;
  logic [ID_W-1:0] winner_id_n, first_id;
  logic [RAND_W-1:0] rnd;
  logic start_q, start_edge, tick, no_winner_n, restart, finish;

  reaction_lfsr #(.SEED(LFSR_SEED), .OUT_W(RAND_W)) u_lfsr (.clk(clk), .reset(reset), .value(rnd));

  assign start_edge = start_btn & ~start_q;
  assign react_edge = react_btn & ~react_q;
  assign valid = react_edge & ~false_start;
  assign tick = tick_cnt == TICK_W'(TICK_DIV - 1);
  assign led = state == REACT;
  assign busy = state == WAIT || state == REACT;
  assign restart = state_n != state && (state_n == WAIT || state_n == REACT);
  assign finish = state_n == DONE && state != DONE;

  always_comb begin
    first_id = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--)
      if (valid[i]) first_id = ID_W'(i);
  end

  always_comb begin
    state_n = state;
    delay_n = delay;
    elapsed_n = elapsed;
    fs_n = false_start;
    no_winner_n = no_winner;
    winner_id_n = winner_id;
    winner_time_n = winner_time;
    case (state)
      IDLE, DONE: if (start_edge) begin
        state_n = WAIT;
        delay_n = (TIME_W+1)'(MIN_DELAY_MS) + (TIME_W+1)'(rnd);
        fs_n = '0;
        no_winner_n = 1'b0;
        winner_id_n = '0;
        winner_time_n = '0;
      end
      WAIT: begin
        fs_n = false_start | react_edge;
        if (&fs_n) begin
          state_n = DONE;
          no_winner_n = 1'b1;
        end else if (tick) begin
          delay_n = delay - (TIME_W+1)'(1);
          if (delay == (TIME_W+1)'(1)) begin
            state_n = REACT;
            elapsed_n = '0;
          end
        end
      end
      REACT: if (|valid) begin
        state_n = DONE;
        winner_id_n = first_id;
        winner_time_n = elapsed;
      end else if (tick) begin
        if (elapsed == T_MAX) begin
          state_n = DONE;
          no_winner_n = 1'b1;
          winner_time_n = T_MAX;
        end else elapsed_n = elapsed + TIME_W'(1);
      end
      default: ;
    endcase
  end

  // Button history tracks the pins even during reset, so a button held across reset is not a press
  always_ff @(posedge clk) begin
    start_q <= start_btn;
    react_q <= react_btn;
    if (reset) begin
      state <= IDLE;
      tick_cnt <= '0;
      delay <= '0;
      elapsed <= '0;
      false_start <= '0;
      no_winner <= 1'b0;
      winner_id <= '0;
      winner_time <= '0;
      result_valid <= 1'b0;
      best_time <= '1;
      best_id <= '0;
    end else begin
      state <= state_n;
      tick_cnt <= (restart || tick) ? '0 : tick_cnt + TICK_W'(1);
      delay <= delay_n;
      elapsed <= elapsed_n;
      false_start <= fs_n;
      no_winner <= no_winner_n;
      winner_id <= winner_id_n;
      winner_time <= winner_time_n;
      result_valid <= finish;
      if (finish && !no_winner_n && winner_time_n < best_time) begin
        best_time <= winner_time_n;
        best_id <= winner_id_n;
      end
    end
  end
endmodule

// File: tb/tb_reaction_arena.sv
// tb_reaction_arena: directed checks of rounds, tie-breaks, false starts, best tracking, reset and timeout
module tb_reaction_arena;
  logic clk = 0, reset = 1, start_btn = 0, start2 = 0;
  logic [3:0] react_btn = 0, react2 = 0;
  logic led, busy, result_valid, no_winner;
  logic [1:0] winner_id, best_id;
  logic [13:0] winner_time, best_time;
  logic [3:0] false_start;
  logic led2, busy2, rv2, nw2;
  logic [1:0] wid2, bid2;
  logic [3:0] wt2, bt2, fs2;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  reaction_arena #(.N_PLAYERS(4), .TIME_W(14), .TICK_DIV(4), .MIN_DELAY_MS(3), .RAND_W(2)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .react_btn(react_btn),
    .led(led), .busy(busy), .result_valid(result_valid), .no_winner(no_winner),
    .winner_id(winner_id), .winner_time(winner_time), .false_start(false_start),
    .best_time(best_time), .best_id(best_id));

  reaction_arena #(.N_PLAYERS(4), .TIME_W(4), .TICK_DIV(4), .MIN_DELAY_MS(3), .RAND_W(2)) dut2 (
    .clk(clk), .reset(reset), .start_btn(start2), .react_btn(react2),
    .led(led2), .busy(busy2), .result_valid(rv2), .no_winner(nw2),
    .winner_id(wid2), .winner_time(wt2), .false_start(fs2),
    .best_time(bt2), .best_id(bid2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_led(input int which);
    int n = 0;
    while ((which == 1 ? led : led2) !== 1'b1 && n < 200) begin
      cyc(1);
      n++;
    end
    chk("led_wait", 32'(n < 200), 1);
  endtask

  task automatic start_round();
    start_btn = 1;
    cyc(1);
    start_btn = 0;
    chk("busy_start", busy, 1);
  endtask

  task automatic play(input logic [3:0] pre, input logic [3:0] mask, input int e,
                      input logic [1:0] id, input logic [13:0] t, input logic [13:0] bt,
                      input logic [1:0] bid);
    start_round();
    if (pre != 0) begin
      react_btn = pre;
      cyc(1);
      react_btn = 0;
      chk("fs_wait", false_start, pre);
      chk("busy_fs", busy, 1);
    end
    wait_led(1);
    cyc(4 * e);
    react_btn = mask;
    cyc(1);
    react_btn = 0;
    chk("rv_pulse", result_valid, 1);
    chk("no_winner", no_winner, 0);
    chk("winner_id", winner_id, id);
    chk("winner_time", winner_time, t);
    chk("led_done", led, 0);
    chk("best_time", best_time, bt);
    chk("best_id", best_id, bid);
    cyc(1);
    chk("rv_one_cycle", result_valid, 0);
    chk("winner_hold", winner_id, id);
  endtask

  initial begin
    cyc(2);
    reset = 0;
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_nw", no_winner, 0);
    chk("rst_wid", winner_id, 0);
    chk("rst_wt", winner_time, 0);
    chk("rst_fs", false_start, 0);
    chk("rst_best", best_time, 14'h3FFF);
    chk("rst_bid", best_id, 0);
    play(4'b0000, 4'b0100, 5, 2, 5, 5, 2);
    play(4'b0010, 4'b1010, 6, 3, 6, 5, 2);
    play(4'b0000, 4'b0101, 7, 0, 7, 5, 2);
    start_round();
    react_btn = 4'b1111;
    cyc(1);
    react_btn = 0;
    chk("all_fs_rv", result_valid, 1);
    chk("all_fs_nw", no_winner, 1);
    chk("all_fs_led", led, 0);
    chk("all_fs_busy", busy, 0);
    chk("all_fs_flags", false_start, 4'b1111);
    chk("all_fs_best", best_time, 5);
    cyc(3);
    chk("all_fs_hold", no_winner, 1);
    chk("all_fs_rv_low", result_valid, 0);
    play(4'b0000, 4'b0010, 9, 1, 9, 5, 2);
    play(4'b0000, 4'b1000, 5, 3, 5, 5, 2);
    play(4'b0000, 4'b0001, 3, 0, 3, 3, 0);
    start_round();
    wait_led(1);
    cyc(5);
    start_btn = 1;
    cyc(1);
    chk("start_ignored", led, 1);
    reset = 1;
    cyc(1);
    chk("abort_led", led, 0);
    chk("abort_busy", busy, 0);
    chk("abort_best", best_time, 14'h3FFF);
    chk("abort_bid", best_id, 0);
    reset = 0;
    cyc(4);
    chk("held_start", busy, 0);
    start_btn = 0;
    cyc(1);
    start_btn = 1;
    cyc(1);
    chk("restart_busy", busy, 1);
    start_btn = 0;
    start2 = 1;
    cyc(1);
    start2 = 0;
    wait_led(2);
    cyc(63);
    chk("sat_led", led2, 1);
    chk("sat_rv_early", rv2, 0);
    cyc(1);
    chk("sat_rv", rv2, 1);
    chk("sat_nw", nw2, 1);
    chk("sat_wt", wt2, 15);
    chk("sat_led_off", led2, 0);
    chk("sat_best", bt2, 15);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
